// File: rtl/note_highway_pkg.sv
// Shared definitions for the note highway: scroller FSM states and a lane popcount helper.
package note_highway_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRIME,
        ST_PLAY,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int POP_W = 6;

    // Counts set bits of a lane vector; callers zero-extend lanes into the 32-bit argument.
    function automatic logic [POP_W-1:0] popcount(input logic [31:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {{(POP_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/note_highway_hit_judge.sv
// Strike-row judge: latches key rising edges between judgements, scores hits/misses into
// saturating totals and raises one-cycle hit/miss pulses.
module hit_judge
    import note_highway_pkg::*;
#(
    parameter int LANES = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             restart,
    input  logic             judge,
    input  logic [LANES-1:0] keys,
    input  logic [LANES-1:0] row0,
    output logic             hit_pulse,
    output logic             miss_pulse,
    output logic [CNT_W-1:0] hit_total,
    output logic [CNT_W-1:0] miss_total
);

    logic [LANES-1:0] keys_prev_reg;
    logic [LANES-1:0] press_reg;
    logic [LANES-1:0] window;
    logic [LANES-1:0] hits;
    logic [LANES-1:0] misses;
    logic [POP_W-1:0] hit_cnt;
    logic [POP_W-1:0] miss_cnt;

    // A rising edge in the judging cycle still belongs to the window being judged.
    assign window   = press_reg | (keys & ~keys_prev_reg);
    assign hits     = row0 & window;
    assign misses   = row0 ^ window;
    assign hit_cnt  = popcount(32'(hits));
    assign miss_cnt = popcount(32'(misses));

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [CNT_W+POP_W-1:0] s;
        s = {{POP_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        return (s > {{POP_W{1'b0}}, {CNT_W{1'b1}}}) ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_prev_reg <= '0;
            press_reg     <= '0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            hit_total     <= '0;
            miss_total    <= '0;
        end else if (clear) begin
            keys_prev_reg <= '0;
            press_reg     <= '0;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            hit_total     <= '0;
            miss_total    <= '0;
        end else begin
            keys_prev_reg <= keys;
            hit_pulse     <= 1'b0;
            miss_pulse    <= 1'b0;
            if (restart) begin
                press_reg  <= '0;
                hit_total  <= '0;
                miss_total <= '0;
            end else if (judge) begin
                press_reg  <= '0;
                hit_pulse  <= |hits;
                miss_pulse <= |misses;
                hit_total  <= sat_add(hit_total, hit_cnt);
                miss_total <= sat_add(miss_total, miss_cnt);
            end else begin
                press_reg <= window;
            end
        end
    end

endmodule

// File: rtl/note_highway.sv
// Multi-lane note scroller: fetches pattern rows from a latency-MEM_LAT RAM, injects one row
// every SPACING steps into a LANES x DEPTH grid and judges the strike row against key presses.
module note_highway
    import note_highway_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 7,
    parameter int SPACING = 4,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   run,
    input  logic                   step,
    input  logic                   loop,
    input  logic [ADDR_W-1:0]      pattern_len,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic [LANES-1:0]       mem_q,
    input  logic [LANES-1:0]       hit_keys,
    output logic [LANES*DEPTH-1:0] lane_grid,
    output logic                   hit_pulse,
    output logic                   miss_pulse,
    output logic [CNT_W-1:0]       hit_total,
    output logic [CNT_W-1:0]       miss_total,
    output logic                   done
);

    localparam int SP_W = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam int DR_W = $clog2(DEPTH + 1);

    state_t           state_reg;
    logic [SP_W-1:0]  sp_cnt_reg;
    logic [DR_W-1:0]  drain_cnt_reg;
    logic [LANES-1:0] staged_reg;
    logic [MEM_LAT:0] fetch_pipe_reg;

    logic             advance;
    logic             start;
    logic             inject;
    logic             last_row;
    logic             fetch;
    logic             row_ready;
    logic [LANES-1:0] top_row;

    assign advance   = step && run && (state_reg == ST_PLAY || state_reg == ST_DRAIN);
    assign start     = (state_reg == ST_IDLE) && run;
    assign inject    = advance && (state_reg == ST_PLAY) && (sp_cnt_reg == '0);
    assign last_row  = (mem_addr == pattern_len) && !loop;
    assign fetch     = start || (inject && !last_row);
    // Fetch token travels MEM_LAT+1 edges: one for the new address to reach the RAM, MEM_LAT for data.
    assign row_ready = fetch_pipe_reg[MEM_LAT];
    assign top_row   = inject ? staged_reg : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            sp_cnt_reg     <= '0;
            drain_cnt_reg  <= '0;
            staged_reg     <= '0;
            fetch_pipe_reg <= '0;
            mem_addr       <= '0;
            lane_grid      <= '0;
            done           <= 1'b0;
        end else if (clear) begin
            state_reg      <= ST_IDLE;
            sp_cnt_reg     <= '0;
            drain_cnt_reg  <= '0;
            staged_reg     <= '0;
            fetch_pipe_reg <= '0;
            mem_addr       <= '0;
            lane_grid      <= '0;
            done           <= 1'b0;
        end else begin
            fetch_pipe_reg <= {fetch_pipe_reg[MEM_LAT-1:0], fetch};
            if (row_ready) begin
                staged_reg <= mem_q;
            end
            if (advance) begin
                lane_grid <= {top_row, lane_grid[LANES*DEPTH-1:LANES]};
            end
            case (state_reg)
                ST_IDLE: begin
                    mem_addr <= '0;
                    if (run) begin
                        state_reg  <= ST_PRIME;
                        lane_grid  <= '0;
                        sp_cnt_reg <= '0;
                    end
                end
                ST_PRIME: begin
                    if (row_ready) begin
                        state_reg <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (advance) begin
                        sp_cnt_reg <= (sp_cnt_reg == SP_W'(SPACING - 1)) ? '0 : sp_cnt_reg + 1'b1;
                        if (inject) begin
                            if (mem_addr == pattern_len) begin
                                if (loop) begin
                                    mem_addr <= '0;
                                end else begin
                                    state_reg     <= ST_DRAIN;
                                    drain_cnt_reg <= '0;
                                end
                            end else begin
                                mem_addr <= mem_addr + 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (advance) begin
                        drain_cnt_reg <= drain_cnt_reg + 1'b1;
                        if (drain_cnt_reg == DR_W'(DEPTH - 1)) begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!run) begin
                        state_reg <= ST_IDLE;
                        done      <= 1'b0;
                        mem_addr  <= '0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    hit_judge #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) u_judge (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .restart    (start),
        .judge      (advance),
        .keys       (hit_keys),
        .row0       (lane_grid[LANES-1:0]),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .hit_total  (hit_total),
        .miss_total (miss_total)
    );

endmodule

// File: tb/tb_note_highway.sv
// Directed bench for note_highway: a default instance and a CNT_W=2 / MEM_LAT=3 instance share
// stimulus; a step-level reference model feeds a scoreboard queue checked after every STEP.
module tb_note_highway;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, clear, run, step, loop;
    logic [6:0] pattern_len;
    logic [3:0] hit_keys;
    logic [6:0] addr_a, addr_b;
    logic [3:0] qa;
    logic [3:0] qb [3];
    logic [31:0] grid_a, grid_b;
    logic       hp_a, mp_a, hp_b, mp_b, done_a, done_b;
    logic [7:0] ht_a, mt_a;
    logic [1:0] ht_b, mt_b;
    logic [3:0] mem [128];

    // Pattern RAM models: latency 1 for instance A, latency 3 for instance B.
    always @(posedge clk) begin
        qa    <= mem[addr_a];
        qb[0] <= mem[addr_b];
        qb[1] <= qb[0];
        qb[2] <= qb[1];
    end

    note_highway dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .run(run), .step(step), .loop(loop),
        .pattern_len(pattern_len), .mem_addr(addr_a), .mem_q(qa), .hit_keys(hit_keys),
        .lane_grid(grid_a), .hit_pulse(hp_a), .miss_pulse(mp_a),
        .hit_total(ht_a), .miss_total(mt_a), .done(done_a)
    );

    note_highway #(.CNT_W(2), .MEM_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .run(run), .step(step), .loop(loop),
        .pattern_len(pattern_len), .mem_addr(addr_b), .mem_q(qb[2]), .hit_keys(hit_keys),
        .lane_grid(grid_b), .hit_pulse(hp_b), .miss_pulse(mp_b),
        .hit_total(ht_b), .miss_total(mt_b), .done(done_b)
    );

    typedef struct {
        logic [31:0] grid;
        int          addr;
        int          hit;
        int          miss;
        logic        hp;
        logic        mp;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_grid;
    logic [3:0]  m_press;
    int m_sp, m_addr, m_dcnt, m_hit, m_miss;
    logic m_drain, m_done;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic model_step(input logic [3:0] k);
        exp_t e;
        logic [3:0] row0, inj;
        m_press = m_press | k;
        e.hp = 1'b0;
        e.mp = 1'b0;
        if (run && !m_done) begin
            row0   = m_grid[3:0];
            m_hit  = m_hit + $countones(row0 & m_press);
            m_miss = m_miss + $countones(row0 ^ m_press);
            e.hp   = |(row0 & m_press);
            e.mp   = |(row0 ^ m_press);
            m_press = 4'd0;
            inj    = (!m_drain && m_sp == 0) ? mem[m_addr] : 4'd0;
            m_grid = {inj, m_grid[31:4]};
            if (!m_drain) begin
                if (m_sp == 0) begin
                    if (m_addr == int'(pattern_len)) begin
                        if (loop) m_addr = 0;
                        else begin
                            m_drain = 1'b1;
                            m_dcnt  = 0;
                        end
                    end else begin
                        m_addr++;
                    end
                end
                m_sp = (m_sp + 1) % 4;
            end else begin
                m_dcnt++;
                if (m_dcnt == 8) m_done = 1'b1;
            end
        end
        e.grid = m_grid;
        e.addr = m_addr;
        e.hit  = m_hit;
        e.miss = m_miss;
        e.done = m_done;
        sb.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        e = sb.pop_front();
        chk("grid_a", 64'(grid_a), 64'(e.grid));
        chk("grid_b", 64'(grid_b), 64'(e.grid));
        chk("addr_a", 64'(addr_a), 64'(e.addr));
        chk("addr_b", 64'(addr_b), 64'(e.addr));
        chk("hit_total_a", 64'(ht_a), 64'(sat(e.hit, 255)));
        chk("miss_total_a", 64'(mt_a), 64'(sat(e.miss, 255)));
        chk("hit_total_b", 64'(ht_b), 64'(sat(e.hit, 3)));
        chk("miss_total_b", 64'(mt_b), 64'(sat(e.miss, 3)));
        chk("hit_pulse", 64'(hp_a), 64'(e.hp));
        chk("miss_pulse", 64'(mp_a), 64'(e.mp));
        chk("done_a", 64'(done_a), 64'(e.done));
        chk("done_b", 64'(done_b), 64'(e.done));
        $display("step: grid=%08h addr=%0d hit=%0d miss=%0d done=%0b",
                 grid_a, addr_a, ht_a, mt_a, done_a);
    endtask

    // One STEP strobe; keys given here rise in the same cycle as the strobe.
    task automatic do_step(input logic [3:0] k);
        @(negedge clk);
        step = 1'b1;
        hit_keys = k;
        model_step(k);
        @(negedge clk);
        step = 1'b0;
        hit_keys = 4'd0;
        check_pop();
        repeat (5) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        hit_keys = k;
        m_press = m_press | k;
        @(negedge clk);
        hit_keys = 4'd0;
    endtask

    task automatic begin_play(input logic lp, input logic [6:0] pl);
        @(negedge clk);
        loop = lp;
        pattern_len = pl;
        run = 1'b1;
        m_grid = '0; m_press = '0; m_sp = 0; m_addr = 0; m_dcnt = 0;
        m_hit = 0; m_miss = 0; m_drain = 1'b0; m_done = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic end_play();
        @(negedge clk);
        run = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done", 64'(done_a), 64'(0));
        chk("idle_addr", 64'(addr_a), 64'(0));
        chk("idle_hit_hold", 64'(ht_a), 64'(sat(m_hit, 255)));
        chk("idle_miss_hold", 64'(mt_a), 64'(sat(m_miss, 255)));
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 4'd0;
        mem[0] = 4'b1000; mem[1] = 4'b0100; mem[2] = 4'b0010; mem[3] = 4'b0001;
        rst_n = 1'b0; clear = 1'b0; run = 1'b0; step = 1'b0; loop = 1'b0;
        pattern_len = 7'd3; hit_keys = 4'd0;
        repeat (3) @(negedge clk);
        chk("rst_grid", 64'(grid_a), 64'(0));
        chk("rst_totals", 64'({ht_a, mt_a}), 64'(0));
        chk("rst_addr", 64'(addr_a), 64'(0));
        chk("rst_done", 64'(done_a), 64'(0));
        rst_n = 1'b1;

        // Four-row pattern, no keys: every note is a miss, then drain to DONE.
        begin_play(1'b0, 7'd3);
        for (int s = 1; s <= 21; s++) begin
            do_step(4'd0);
            if (s == 1) chk("row7_first", 64'(grid_a[31:28]), 64'(4'b1000));
            if (s == 8) chk("row0_eighth", 64'(grid_a[3:0]), 64'(4'b1000));
        end
        chk("t2_miss", 64'(mt_a), 64'(4));
        chk("t2_miss_sat", 64'(mt_b), 64'(3));
        chk("t2_done", 64'(done_a), 64'(1));
        end_play();

        // Same pattern with matching presses (one coincident with STEP) and one stray press.
        begin_play(1'b0, 7'd3);
        for (int s = 1; s <= 21; s++) begin
            if (s == 10) press(4'b0001);
            if (s == 13) begin
                do_step(m_grid[3:0]);
            end else begin
                if (m_grid[3:0] != 4'd0) press(m_grid[3:0]);
                do_step(4'd0);
            end
        end
        chk("t3_hit", 64'(ht_a), 64'(4));
        chk("t3_miss", 64'(mt_a), 64'(1));
        end_play();

        // Looping two-row pattern with a pause in the middle; DONE must never rise.
        begin_play(1'b1, 7'd1);
        for (int s = 1; s <= 28; s++) begin
            if (s == 11) begin
                @(negedge clk);
                run = 1'b0;
                for (int p = 0; p < 5; p++) do_step(4'd0);
                @(negedge clk);
                run = 1'b1;
            end
            do_step(4'd0);
        end
        chk("t4_miss_sat_b", 64'(mt_b), 64'(3));

        // Asynchronous reset mid-play with a populated grid.
        chk("t1_grid_busy", 64'(grid_a != 32'd0), 64'(1));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t1_grid", 64'(grid_a), 64'(0));
        chk("t1_totals", 64'({ht_a, mt_a, ht_b, mt_b}), 64'(0));
        chk("t1_addr", 64'(addr_a), 64'(0));
        chk("t1_done", 64'(done_a), 64'(0));
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
